// File: rtl/proc_pkg.sv
// Shared definitions for the bus-processor control unit: opcodes, state encoding, IR fields.
package proc_pkg;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // IR = {III opcode, XXX dest, YYY src}
  localparam int IR_OP_MSB  = 8;
  localparam int IR_OP_LSB  = 6;
  localparam int IR_X_MSB   = 5;
  localparam int IR_X_LSB   = 3;
  localparam int IR_Y_MSB   = 2;
  localparam int IR_Y_LSB   = 0;
  localparam int IR_SUB_BIT = 6;

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 register-select decoder; register n drives bit (7-n), so R0 is the MSB.
module dec3to8 (
  input  logic [2:0] W,
  input  logic       En,
  output logic [7:0] Y
);

  always_comb begin
    Y = 8'b0;
    if (En) Y = 8'b1000_0000 >> W;
  end

endmodule

// File: rtl/proc_control.sv
// Multi-cycle T0..T3 control unit for the 8-register bus processor.
// Optional retired-instruction counter enabled by defining PROC_INSTR_COUNT_EN.
module proc_control
  import proc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Run,
  input  logic [8:0]       IR,
  output logic             IRin,
  output logic [7:0]       Rin,
  output logic [7:0]       Rout,
  output logic             Gout,
  output logic             DINout,
  output logic             Ain,
  output logic             Gin,
  output logic             AddSub,
  output logic             Done,
  output logic [CNT_W-1:0] instr_count
);

  state_t     state, state_next;
  logic [2:0] opcode;
  logic [7:0] x_sel, y_sel;

  assign opcode = IR[IR_OP_MSB:IR_OP_LSB];

  dec3to8 u_dec_x (.W(IR[IR_X_MSB:IR_X_LSB]), .En(1'b1), .Y(x_sel));
  dec3to8 u_dec_y (.W(IR[IR_Y_MSB:IR_Y_LSB]), .En(1'b1), .Y(y_sel));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= T0;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    IRin       = 1'b0;
    Rin        = 8'b0;
    Rout       = 8'b0;
    Gout       = 1'b0;
    DINout     = 1'b0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    AddSub     = 1'b0;
    Done       = 1'b0;
    case (state)
      T0: begin
        // no IR load while reset is held, so every enable is quiet in reset
        IRin       = Run & Resetn;
        state_next = Run ? T1 : T0;
      end
      T1: begin
        state_next = T0;
        case (opcode)
          OP_MV: begin
            Rout = y_sel;
            Rin  = x_sel;
            Done = 1'b1;
          end
          OP_MVI: begin
            DINout = 1'b1;
            Rin    = x_sel;
            Done   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            Rout       = x_sel;
            Ain        = 1'b1;
            state_next = T2;
          end
          default: Done = 1'b1;
        endcase
      end
      T2: begin
        Rout       = y_sel;
        Gin        = 1'b1;
        AddSub     = IR[IR_SUB_BIT];
        state_next = T3;
      end
      T3: begin
        Gout       = 1'b1;
        Rin        = x_sel;
        Done       = 1'b1;
        state_next = T0;
      end
      default: state_next = T0;
    endcase
  end

`ifdef PROC_INSTR_COUNT_EN
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)   instr_count <= '0;
    else if (Done) instr_count <= instr_count + CNT_W'(1);
  end
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_proc_control.sv
// Directed self-checking bench for proc_control; expected output vectors are hand-computed.
module tb_proc_control;

  localparam int CNT_W = 16;

  logic             Clock = 1'b0;
  logic             Resetn;
  logic             Run;
  logic [8:0]       IR;
  logic             IRin, Gout, DINout, Ain, Gin, AddSub, Done;
  logic [7:0]       Rin, Rout;
  logic [CNT_W-1:0] instr_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  bit bus_mon = 1'b0;

  proc_control #(.CNT_W(CNT_W)) dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .IR(IR),
    .IRin(IRin), .Rin(Rin), .Rout(Rout), .Gout(Gout), .DINout(DINout),
    .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .Done(Done), .instr_count(instr_count)
  );

  always #5 Clock = ~Clock;

  logic [22:0] outs;
  assign outs = {IRin, Rin, Rout, Gout, DINout, Ain, Gin, AddSub, Done};

  // builds an expected output vector in the same field order as outs
  function automatic logic [22:0] ev(input logic irin, input logic [7:0] rin,
                                     input logic [7:0] rout, input logic gout,
                                     input logic din, input logic ain, input logic gin,
                                     input logic addsub, input logic done);
    return {irin, rin, rout, gout, din, ain, gin, addsub, done};
  endfunction

  function automatic logic [CNT_W-1:0] cnt_exp();
`ifdef PROC_INSTR_COUNT_EN
    return CNT_W'(exp_cnt);
`else
    return '0;
`endif
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  always @(negedge Clock) begin
    if (bus_mon) begin
      checks++;
      if (($countones(Rout) + int'(Gout) + int'(DINout)) > 1) begin
        errors++;
        $display("FAIL bus_excl: Rout=%b Gout=%b DINout=%b, required at most one driver",
                 Rout, Gout, DINout);
      end
    end
  end

  task automatic test_reset();
    Resetn = 1'b0; Run = 1'b1; IR = 9'b010_001_010;
    #3;
    checks++;
    if (outs !== 23'd0) begin errors++; $display("FAIL reset_outs: got %h required 0", outs); end
    checks++;
    if (instr_count !== '0) begin errors++; $display("FAIL reset_cnt: got %0d required 0", instr_count); end
    step(); step();
    Run = 1'b0; Resetn = 1'b1; exp_cnt = 0;
    bus_mon = 1'b1;
    step(); step();
    checks++;
    if (outs !== 23'd0) begin errors++; $display("FAIL idle_outs: got %h required 0", outs); end
  endtask

  task automatic test_mvi();
    IR = 9'b001_010_000; Run = 1'b1;
    #1;
    checks++;
    if (outs !== ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL mvi_t0: got %h required %h", outs, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
    end
    step(); Run = 1'b0; #1;
    checks++;
    if (outs !== ev(0, 8'b0010_0000, 8'h00, 0, 1, 0, 0, 0, 1)) begin
      errors++; $display("FAIL mvi_t1: got %h required %h", outs, ev(0, 8'b0010_0000, 8'h00, 0, 1, 0, 0, 0, 1));
    end
    step(); exp_cnt++;
    checks++;
    if (outs !== 23'd0) begin errors++; $display("FAIL mvi_back_t0: got %h required 0", outs); end
    checks++;
    if (instr_count !== cnt_exp()) begin
      errors++; $display("FAIL mvi_cnt: got %0d required %0d", instr_count, cnt_exp());
    end
  endtask

  task automatic test_mv(input logic [8:0] ir, input logic [7:0] rin_e, input logic [7:0] rout_e);
    IR = ir; Run = 1'b1;
    step(); Run = 1'b0; #1;
    checks++;
    if (outs !== ev(0, rin_e, rout_e, 0, 0, 0, 0, 0, 1)) begin
      errors++; $display("FAIL mv_t1 ir=%b: got %h required %h", ir, outs, ev(0, rin_e, rout_e, 0, 0, 0, 0, 0, 1));
    end
    step(); exp_cnt++;
    checks++;
    if (outs !== 23'd0) begin errors++; $display("FAIL mv_back_t0 ir=%b: got %h required 0", ir, outs); end
  endtask

  task automatic test_sub();
    IR = 9'b011_000_101; Run = 1'b1;
    step(); Run = 1'b1; #1;
    checks++;
    if (outs !== ev(0, 8'h00, 8'b1000_0000, 0, 0, 1, 0, 0, 0)) begin
      errors++; $display("FAIL sub_t1: got %h required %h", outs, ev(0, 8'h00, 8'b1000_0000, 0, 0, 1, 0, 0, 0));
    end
    step();
    checks++;
    if (outs !== ev(0, 8'h00, 8'b0000_0100, 0, 0, 0, 1, 1, 0)) begin
      errors++; $display("FAIL sub_t2: got %h required %h", outs, ev(0, 8'h00, 8'b0000_0100, 0, 0, 0, 1, 1, 0));
    end
    Run = 1'b0;
    step();
    checks++;
    if (outs !== ev(0, 8'b1000_0000, 8'h00, 1, 0, 0, 0, 0, 1)) begin
      errors++; $display("FAIL sub_t3: got %h required %h", outs, ev(0, 8'b1000_0000, 8'h00, 1, 0, 0, 0, 0, 1));
    end
    step(); exp_cnt++;
    checks++;
    if (outs !== 23'd0) begin errors++; $display("FAIL sub_back_t0: got %h required 0", outs); end
  endtask

  task automatic test_nop();
    IR = 9'b101_011_100; Run = 1'b1;
    step(); Run = 1'b0; #1;
    checks++;
    if (outs !== ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1)) begin
      errors++; $display("FAIL nop_t1: got %h required %h", outs, ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1));
    end
    step(); exp_cnt++;
    checks++;
    if (instr_count !== cnt_exp()) begin
      errors++; $display("FAIL nop_cnt: got %0d required %0d", instr_count, cnt_exp());
    end
  endtask

  task automatic test_abort();
    IR = 9'b010_100_110; Run = 1'b1;
    step(); Run = 1'b0;
    step();
    checks++;
    if (outs !== ev(0, 8'h00, 8'b0000_0010, 0, 0, 0, 1, 0, 0)) begin
      errors++; $display("FAIL abort_t2: got %h required %h", outs, ev(0, 8'h00, 8'b0000_0010, 0, 0, 0, 1, 0, 0));
    end
    #2 Resetn = 1'b0; #1;
    exp_cnt = 0;
    checks++;
    if (outs !== 23'd0) begin errors++; $display("FAIL abort_drop: got %h required 0", outs); end
    checks++;
    if (instr_count !== '0) begin errors++; $display("FAIL abort_cnt: got %0d required 0", instr_count); end
    step(); Resetn = 1'b1;
    step();
    checks++;
    if (outs !== 23'd0) begin errors++; $display("FAIL abort_no_t3: got %h required 0", outs); end
    IR = 9'b001_101_000; Run = 1'b1;
    step(); Run = 1'b0; #1;
    checks++;
    if (outs !== ev(0, 8'b0000_0100, 8'h00, 0, 1, 0, 0, 0, 1)) begin
      errors++; $display("FAIL abort_restart: got %h required %h", outs, ev(0, 8'b0000_0100, 8'h00, 0, 1, 0, 0, 0, 1));
    end
    step(); exp_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [22:0] exp_vec [1:8];
    logic [8:0]  ir_at   [1:8];
    int          done_cycles;
    exp_vec[1] = ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    exp_vec[2] = ev(0, 8'b0000_0010, 8'h00, 0, 1, 0, 0, 0, 1);
    exp_vec[3] = ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    exp_vec[4] = ev(0, 8'h00, 8'b0100_0000, 0, 0, 1, 0, 0, 0);
    exp_vec[5] = ev(0, 8'h00, 8'b0001_0000, 0, 0, 0, 1, 0, 0);
    exp_vec[6] = ev(0, 8'b0100_0000, 8'h00, 1, 0, 0, 0, 0, 1);
    exp_vec[7] = ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    exp_vec[8] = ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1);
    ir_at[1] = 9'b001_110_000; ir_at[2] = 9'b001_110_000;
    ir_at[3] = 9'b010_001_011; ir_at[4] = 9'b010_001_011;
    ir_at[5] = 9'b010_001_011; ir_at[6] = 9'b010_001_011;
    ir_at[7] = 9'b111_000_000; ir_at[8] = 9'b111_000_000;
    done_cycles = 0;
    Run = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) step();
      IR = ir_at[c];
      #1;
      checks++;
      if (outs !== exp_vec[c]) begin
        errors++; $display("FAIL b2b_cycle%0d: got %h required %h", c, outs, exp_vec[c]);
      end
      if (Done) done_cycles = done_cycles * 10 + c;
    end
    Run = 1'b0;
    step(); exp_cnt += 3;
    checks++;
    if (done_cycles != 268) begin
      errors++; $display("FAIL b2b_done_cycles: got %0d required 268", done_cycles);
    end
    checks++;
    if (outs !== 23'd0) begin errors++; $display("FAIL b2b_idle: got %h required 0", outs); end
    checks++;
    if (instr_count !== cnt_exp()) begin
      errors++; $display("FAIL b2b_cnt: got %0d required %0d", instr_count, cnt_exp());
    end
  endtask

  initial begin
    test_reset();
    test_mvi();
    test_mv(9'b000_111_001, 8'b0000_0001, 8'b0100_0000);
    test_mv(9'b000_011_011, 8'b0001_0000, 8'b0001_0000);
    test_sub();
    test_nop();
    test_abort();
    test_back_to_back();
    bus_mon = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule
